pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter RST_HOLD, default 2, number of cycles after reset release during which all stage enables are held low.
REQ-002 Parameter LU_CYCLES, default 1, range 1-7, number of bubble cycles inserted per load-use hazard.
REQ-003 Parameter FLUSH_CYCLES, default 1, range 1-7, number of cycles decode invalidate is asserted per taken branch.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 async_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 dec_rs1_addr  in  5  rs1 field of the instruction entering decode.
REQ-007 dec_rs2_addr  in  5  rs2 field of the instruction entering decode.
REQ-008 dec_uses_rs1, dec_uses_rs2  in  1 each  decoded instruction reads rs1 / rs2.
REQ-009 ex_rd_addr  in  5  destination register of the instruction in execute.
REQ-010 ex_is_load  in  1  instruction in execute is a load.
REQ-011 ex_branch_taken  in  1  execute resolved a taken branch/jump this cycle.
REQ-012 mem_busy  in  1  memory access outstanding; whole pipeline must freeze.
REQ-013 fetch_en  out  1  fetch stage clock enable.
REQ-014 decode_en  out  1  decode stage clock enable (drives decode clk_en).
REQ-015 invalidate  out  1  clears decode output buffer (bubble into execute).
REQ-016 fetch_flush  out  1  discards the instruction held in fetch.
REQ-017 stall_cnt  out  16  saturating count of cycles with decode_en=0 outside reset hold.
REQ-018 flush_cnt  out  16  saturating count of accepted taken branches.

Function
REQ-019 FSM states: HOLD, RUN, LU_STALL, FLUSH; 3-bit down-counter cnt shared by HOLD, LU_STALL, FLUSH.
REQ-020 Outputs are combinational from state and current-cycle inputs; a hazard takes effect in the cycle it is presented.
REQ-021 Priority in every non-HOLD state: mem_busy > ex_branch_taken > load-use hazard.
REQ-022 HOLD: fetch_en=0, decode_en=0, invalidate=1, fetch_flush=1; cnt decrements; at cnt==1 next state RUN; RST_HOLD=0 treated as 1.
REQ-023 mem_busy=1 (any state but HOLD): fetch_en=0, decode_en=0, invalidate=0, fetch_flush=0; state, cnt and counters frozen except stall_cnt increments; ex_branch_taken and hazards ignored that cycle.
REQ-024 Hazard = ex_is_load & ex_rd_addr!=0 & ((dec_uses_rs1 & dec_rs1_addr==ex_rd_addr) | (dec_uses_rs2 & dec_rs2_addr==ex_rd_addr)).
REQ-025 RUN, no event: fetch_en=1, decode_en=1, invalidate=0, fetch_flush=0.
REQ-026 RUN, hazard: fetch_en=0, decode_en=0, invalidate=1; if LU_CYCLES>1 go LU_STALL with cnt=LU_CYCLES-1, else stay RUN.
REQ-027 LU_STALL: same outputs as REQ-026; cnt decrements; at cnt==1 next RUN; hazard inputs not re-evaluated.
REQ-028 Taken branch (RUN or LU_STALL): fetch_en=1, decode_en=1, invalidate=1, fetch_flush=1; flush_cnt increments; if FLUSH_CYCLES>1 go FLUSH with cnt=FLUSH_CYCLES-1, else RUN; pending LU_STALL is abandoned.
REQ-029 FLUSH: fetch_en=1, decode_en=1, invalidate=1, fetch_flush=0; hazards ignored; new ex_branch_taken reloads cnt=FLUSH_CYCLES-1 and increments flush_cnt; at cnt==1 next RUN.
REQ-030 stall_cnt increments each non-HOLD cycle with decode_en=0; both counters saturate at 16'hFFFF, no wrap.

Reset
REQ-031 async_rst_n=0: state=HOLD, cnt=RST_HOLD, stall_cnt=0, flush_cnt=0 immediately, independent of clk.
REQ-032 While and immediately after reset: fetch_en=0, decode_en=0, invalidate=1, fetch_flush=1.
REQ-033 Reset asserted mid-stall or mid-flush aborts it with no residual effect.

Verification
REQ-034 Reset release, defaults, no events -> enables 0 for exactly 2 cycles, then fetch_en=decode_en=1, counters 0.
REQ-035 ex_is_load=1, ex_rd_addr=5, dec_uses_rs2=1, dec_rs2_addr=5 -> one cycle decode_en=0, invalidate=1, stall_cnt=1; same with ex_rd_addr=0 -> no stall.
REQ-036 LU_CYCLES=3, hazard then branch on 2nd stall cycle -> stall 1 cycle, then branch outputs, flush_cnt=1, state RUN after.
REQ-037 mem_busy=1 for 4 cycles with ex_branch_taken=1 -> all enables 0, flush_cnt unchanged, stall_cnt+4; branch accepted on first cycle mem_busy=0.
REQ-038 Preload stall_cnt to 16'hFFFE via 2 extra stall cycles -> stays 16'hFFFF.
REQ-039 async_rst_n pulsed low mid-FLUSH (FLUSH_CYCLES=4) between clock edges -> outputs switch to HOLD values asynchronously, counters 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: gates fetch/decode enables for reset hold,
// load-use bubbles, taken-branch flushes and memory back-pressure.
module pipeline_ctrl #(
    parameter int RST_HOLD     = 2,
    parameter int LU_CYCLES    = 1,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        async_rst_n,
    input  logic [4:0]  dec_rs1_addr,
    input  logic [4:0]  dec_rs2_addr,
    input  logic        dec_uses_rs1,
    input  logic        dec_uses_rs2,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_is_load,
    input  logic        ex_branch_taken,
    input  logic        mem_busy,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        invalidate,
    output logic        fetch_flush,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    // state    | meaning
    // HOLD     | post-reset quiet period, enables low
    // RUN      | normal issue
    // LU_STALL | remaining load-use bubble cycles
    // FLUSH    | remaining decode-invalidate cycles after a taken branch
    localparam logic [1:0] S_HOLD  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_LU    = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    // A zero hold time still spends one cycle in HOLD.
    localparam logic [2:0] HOLD_INIT = (RST_HOLD < 1) ? 3'd1 :
                                       (RST_HOLD > 7) ? 3'd7 : 3'(RST_HOLD);
    localparam logic [2:0] LU_RELOAD = 3'(LU_CYCLES - 1);
    localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYCLES - 1);

    logic [1:0]  r_state;
    logic [2:0]  r_cnt;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    logic [1:0]  w_state_nxt;
    logic [2:0]  w_cnt_nxt;
    logic        w_stall_inc;
    logic        w_flush_inc;
    logic        w_hazard;

    assign w_hazard = ex_is_load && (ex_rd_addr != 5'd0) &&
                      ((dec_uses_rs1 && (dec_rs1_addr == ex_rd_addr)) ||
                       (dec_uses_rs2 && (dec_rs2_addr == ex_rd_addr)));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;
        fetch_en    = 1'b0;
        decode_en   = 1'b0;
        invalidate  = 1'b0;
        fetch_flush = 1'b0;
        if (r_state == S_HOLD) begin
            invalidate  = 1'b1;
            fetch_flush = 1'b1;
            w_cnt_nxt   = r_cnt - 3'd1;
            if (r_cnt <= 3'd1) begin
                w_state_nxt = S_RUN;
            end
        end else if (mem_busy) begin
            w_stall_inc = 1'b1;
        end else if (ex_branch_taken) begin
            fetch_en    = 1'b1;
            decode_en   = 1'b1;
            invalidate  = 1'b1;
            fetch_flush = (r_state != S_FLUSH);
            w_flush_inc = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                w_state_nxt = S_FLUSH;
                w_cnt_nxt   = FL_RELOAD;
            end else begin
                w_state_nxt = S_RUN;
            end
        end else begin
            case (r_state)
                S_FLUSH: begin
                    fetch_en   = 1'b1;
                    decode_en  = 1'b1;
                    invalidate = 1'b1;
                    w_cnt_nxt  = r_cnt - 3'd1;
                    if (r_cnt <= 3'd1) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_LU: begin
                    invalidate  = 1'b1;
                    w_stall_inc = 1'b1;
                    w_cnt_nxt   = r_cnt - 3'd1;
                    if (r_cnt <= 3'd1) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: begin
                    if (w_hazard) begin
                        invalidate  = 1'b1;
                        w_stall_inc = 1'b1;
                        if (LU_CYCLES > 1) begin
                            w_state_nxt = S_LU;
                            w_cnt_nxt   = LU_RELOAD;
                        end
                    end else begin
                        fetch_en  = 1'b1;
                        decode_en = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_state     <= S_HOLD;
            r_cnt       <= HOLD_INIT;
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_stall_inc && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_flush_inc && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
